// File: rtl/cpu_mem_fetch_pkg.sv
// ---------------------------------------------------------------------------
// cpu_mem_fetch_pkg
// Shared definitions for the memory fetch master: default port widths,
// the default output-buffer depth and the fetch FSM state encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package cpu_mem_fetch_pkg;

    localparam int DEFAULT_ADDR_W     = 14;
    localparam int DEFAULT_DATA_W     = 32;
    localparam int DEFAULT_FIFO_DEPTH = 4;

    // Legacy-compatible state codes; the enum below is built from them.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        FETCH_IDLE  = ST_IDLE,
        FETCH_ISSUE = ST_ISSUE,
        FETCH_DRAIN = ST_DRAIN,
        FETCH_DONE  = ST_DONE
    } fetch_state_e;

endpackage

// File: rtl/cpu_mem_fetch_fifo.sv
// ---------------------------------------------------------------------------
// cpu_mem_fetch_fifo
// Synchronous FIFO holding read data between the Avalon-MM read port and the
// stream output. DEPTH must be a power of two, at least 2.
// Ports:
//   clk, reset_n      clock and asynchronous active-low reset
//   push, push_data   write one entry (ignored when full)
//   pop               remove the head entry (ignored when empty)
//   head_data         current head entry
//   count             number of stored entries
//   empty             no entries stored
// ---------------------------------------------------------------------------
module cpu_mem_fetch_fifo #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 4,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic [CNT_W-1:0]  count,
    output logic              empty
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(1'b0);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              do_push_s;
    logic              do_pop_s;

    assign do_push_s = push & (count_r != CNT_FULL);
    assign do_pop_s  = pop & (count_r != CNT_ZERO);

    // Storage, pointers and occupancy; pointers wrap naturally (power-of-2 depth).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= CNT_ZERO;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    assign head_data = mem_r[rd_ptr_r];
    assign count     = count_r;
    assign empty     = (count_r == CNT_ZERO);

endmodule

// File: rtl/cpu_mem_fetch_master.sv
// ---------------------------------------------------------------------------
// cpu_mem_fetch_master
// Fetches word_count consecutive words starting at base_addr over an
// Avalon-MM read master port and streams them out in order through a small
// FIFO. Reads are only issued while buffer occupancy plus reads in flight is
// below FIFO_DEPTH, so the buffer can never overflow.
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   start, base_addr, word_count  fetch request (accepted in IDLE only)
//   busy, done                    status; done pulses once per fetch
//   avm_*                         Avalon-MM read master
//   st_data, st_valid, st_ready   output stream (FIFO head)
//   checksum                      only with CPU_MEM_FETCH_CHECKSUM_EN defined:
//                                 running sum of words popped in this fetch
// ---------------------------------------------------------------------------
module cpu_mem_fetch_master
    import cpu_mem_fetch_pkg::*;
#(
    parameter int ADDR_W     = DEFAULT_ADDR_W,
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic [3:0]        avm_byteenable,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_readdatavalid,
    output logic [DATA_W-1:0] st_data,
    output logic              st_valid,
    input  logic              st_ready
`ifdef CPU_MEM_FETCH_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W:0]    DEPTH_LIMIT = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0]  CNT_ZERO    = CNT_W'(1'b0);
    localparam logic [ADDR_W-1:0] ADDR_ONE    = ADDR_W'(1'b1);
    localparam logic [ADDR_W:0]   WORDS_ONE   = (ADDR_W + 1)'(1'b1);
    localparam logic [ADDR_W:0]   WORDS_ZERO  = (ADDR_W + 1)'(1'b0);

    fetch_state_e      state_r;
    fetch_state_e      state_next_s;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] addr_next_s;
    logic [ADDR_W:0]   remaining_r;
    logic [ADDR_W:0]   remaining_next_s;
    logic [CNT_W-1:0]  outstanding_r;
    logic [CNT_W-1:0]  outstanding_next_s;
    logic [CNT_W-1:0]  fifo_count_s;
    logic [CNT_W-1:0]  fifo_used_next_s;
    logic              read_r;
    logic              read_next_s;
    logic              busy_r;
    logic              done_r;
    logic              issue_s;
    logic              push_s;
    logic              pop_s;
    logic              fifo_empty_s;
    logic              budget_ok_s;
    logic [DATA_W-1:0] fifo_head_s;

    assign issue_s = read_r & ~avm_waitrequest;
    // Responses with nothing in flight are stray and must not enter the buffer.
    assign push_s  = avm_readdatavalid & (outstanding_r != CNT_ZERO);
    assign pop_s   = ~fifo_empty_s & st_ready;

    cpu_mem_fetch_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push_s),
        .push_data (avm_readdata),
        .pop       (pop_s),
        .head_data (fifo_head_s),
        .count     (fifo_count_s),
        .empty     (fifo_empty_s)
    );

    // Next-cycle occupancy: avm_read is registered, so the budget decision
    // for the next cycle must already include this cycle's issue/push/pop.
    always_comb begin
        outstanding_next_s = outstanding_r;
        fifo_used_next_s   = fifo_count_s;
        if (issue_s && !push_s) begin
            outstanding_next_s = outstanding_r + CNT_ONE;
        end else if (!issue_s && push_s) begin
            outstanding_next_s = outstanding_r - CNT_ONE;
        end else begin
            outstanding_next_s = outstanding_r;
        end
        if (push_s && !pop_s) begin
            fifo_used_next_s = fifo_count_s + CNT_ONE;
        end else if (!push_s && pop_s) begin
            fifo_used_next_s = fifo_count_s - CNT_ONE;
        end else begin
            fifo_used_next_s = fifo_count_s;
        end
        budget_ok_s = ({1'b0, fifo_used_next_s} + {1'b0, outstanding_next_s}) < DEPTH_LIMIT;
    end

    // Fetch FSM next state, address/remaining bookkeeping and read request.
    always_comb begin
        state_next_s     = state_r;
        addr_next_s      = addr_r;
        remaining_next_s = remaining_r;
        case (state_r)
            FETCH_IDLE: begin
                if (start) begin
                    addr_next_s      = base_addr;
                    remaining_next_s = word_count;
                    if (word_count == WORDS_ZERO) begin
                        state_next_s = FETCH_DONE;
                    end else begin
                        state_next_s = FETCH_ISSUE;
                    end
                end else begin
                    state_next_s = FETCH_IDLE;
                end
            end
            FETCH_ISSUE: begin
                if (issue_s) begin
                    addr_next_s      = addr_r + ADDR_ONE;
                    remaining_next_s = remaining_r - WORDS_ONE;
                    if (remaining_r == WORDS_ONE) begin
                        state_next_s = FETCH_DRAIN;
                    end else begin
                        state_next_s = FETCH_ISSUE;
                    end
                end else begin
                    state_next_s = FETCH_ISSUE;
                end
            end
            FETCH_DRAIN: begin
                if ((outstanding_r == CNT_ZERO) && fifo_empty_s) begin
                    state_next_s = FETCH_DONE;
                end else begin
                    state_next_s = FETCH_DRAIN;
                end
            end
            FETCH_DONE: begin
                state_next_s = FETCH_IDLE;
            end
            default: begin
                state_next_s = FETCH_IDLE;
            end
        endcase
        read_next_s = (state_next_s == FETCH_ISSUE) &&
                      (remaining_next_s != WORDS_ZERO) && budget_ok_s;
    end

    // State, address, counters and all registered control outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= FETCH_IDLE;
            addr_r        <= {ADDR_W{1'b0}};
            remaining_r   <= WORDS_ZERO;
            outstanding_r <= CNT_ZERO;
            read_r        <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            addr_r        <= addr_next_s;
            remaining_r   <= remaining_next_s;
            outstanding_r <= outstanding_next_s;
            read_r        <= read_next_s;
            busy_r        <= (state_next_s != FETCH_IDLE);
            done_r        <= (state_next_s == FETCH_DONE);
        end
    end

    assign busy           = busy_r;
    assign done           = done_r;
    assign avm_address    = addr_r;
    assign avm_read       = read_r;
    assign avm_byteenable = 4'hF;
    assign st_data        = fifo_head_s;
    assign st_valid       = ~fifo_empty_s;

`ifdef CPU_MEM_FETCH_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_r;

    // Running sum of popped words; restarts on each accepted start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            checksum_r <= {DATA_W{1'b0}};
        end else if ((state_r == FETCH_IDLE) && start) begin
            checksum_r <= {DATA_W{1'b0}};
        end else if (pop_s) begin
            checksum_r <= checksum_r + fifo_head_s;
        end
    end

    assign checksum = checksum_r;
`endif

endmodule

// File: tb/tb_cpu_mem_fetch_master.sv
// ---------------------------------------------------------------------------
// tb_cpu_mem_fetch_master
// Self-checking bench: a randomised Avalon-MM slave over a memory array and
// a stream sink feed a reference model that expects fetch N from base B to
// return mem[(B+i) mod 2^ADDR_W], i = 0..N-1, in order, with one done pulse.
// Define CPU_MEM_FETCH_CHECKSUM_EN to also check the checksum output.
// ---------------------------------------------------------------------------
module tb_cpu_mem_fetch_master;

    localparam int AW    = 14;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk               = 1'b0;
    logic          reset_n           = 1'b0;
    logic          start             = 1'b0;
    logic [AW-1:0] base_addr         = '0;
    logic [AW:0]   word_count        = '0;
    logic          busy;
    logic          done;
    logic [AW-1:0] avm_address;
    logic          avm_read;
    logic [3:0]    avm_byteenable;
    logic          avm_waitrequest   = 1'b0;
    logic [DW-1:0] avm_readdata      = '0;
    logic          avm_readdatavalid = 1'b0;
    logic [DW-1:0] st_data;
    logic          st_valid;
    logic          st_ready          = 1'b0;
`ifdef CPU_MEM_FETCH_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    cpu_mem_fetch_master #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .start             (start),
        .base_addr         (base_addr),
        .word_count        (word_count),
        .busy              (busy),
        .done              (done),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_byteenable    (avm_byteenable),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .st_data           (st_data),
        .st_valid          (st_valid),
        .st_ready          (st_ready)
`ifdef CPU_MEM_FETCH_CHECKSUM_EN
        ,
        .checksum          (checksum)
`endif
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:(1 << AW) - 1];
    logic [AW-1:0] issued_q [$];
    logic [AW-1:0] pend_q [$];
    logic [DW-1:0] recv_q [$];
    int  done_cnt  = 0;
    int  max_occ   = 0;
    int  checks    = 0;
    int  failures  = 0;
    bit  rand_wait  = 1'b0;
    bit  rand_lat   = 1'b0;
    bit  rand_ready = 1'b0;
    bit  ready_en   = 1'b1;

    // Slave, sink and monitor; every decision here applies to the next rising edge.
    always @(negedge clk) begin
        if (pend_q.size() > 0 && (!rand_lat || $urandom_range(0, 2) != 0)) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = mem[pend_q.pop_front()];
        end else begin
            avm_readdatavalid = 1'b0;
            avm_readdata      = $urandom;
        end
        avm_waitrequest = rand_wait && ($urandom_range(0, 2) == 0);
        if (reset_n && avm_read && !avm_waitrequest) begin
            issued_q.push_back(avm_address);
            pend_q.push_back(avm_address);
        end
        st_ready = ready_en && (!rand_ready || $urandom_range(0, 1) == 1);
        if (reset_n && st_valid && st_ready) recv_q.push_back(st_data);
        if (reset_n && done) done_cnt++;
        if (issued_q.size() - recv_q.size() > max_occ) max_occ = issued_q.size() - recv_q.size();
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic start_fetch(input logic [AW-1:0] b, input logic [AW:0] n);
        issued_q.delete();
        recv_q.delete();
        done_cnt   = 0;
        max_occ    = 0;
        start      = 1'b1;
        base_addr  = b;
        word_count = n;
        cycles(1);
        start      = 1'b0;
        base_addr  = AW'($urandom);
        word_count = (AW + 1)'($urandom);
    endtask

    task automatic wait_done(input int budget, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (done_cnt != 0) begin
                timed_out = 1'b0;
                break;
            end
            cycles(1);
        end
    endtask

    task automatic test_reset();
        #3;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (avm_read !== 1'b0) begin failures++; $display("FAIL reset_read: got %b expected 0", avm_read); end
        checks++; if (avm_address !== 14'h0000) begin failures++; $display("FAIL reset_addr: got %h expected 0000", avm_address); end
        checks++; if (st_valid !== 1'b0) begin failures++; $display("FAIL reset_st_valid: got %b expected 0", st_valid); end
        checks++; if (avm_byteenable !== 4'hF) begin failures++; $display("FAIL byteenable: got %h expected f", avm_byteenable); end
        cycles(3);
        reset_n = 1'b1;
        cycles(2);
    endtask

    task automatic test_fetch_cases();
        logic [AW-1:0] b;
        logic [AW-1:0] ea;
        logic [AW-1:0] ga;
        logic [AW:0]   n;
        logic [DW-1:0] ed;
        logic [DW-1:0] gd;
        logic [DW-1:0] sum;
        bit            to;
        for (int k = 0; k < 8; k++) begin
            ready_en = 1'b1;
            if (k == 0) begin
                b = 14'h0010; n = 15'd3;
                rand_wait = 1'b0; rand_lat = 1'b0; rand_ready = 1'b0;
            end else if (k == 1) begin
                b = 14'h3FFE; n = 15'd4;
                rand_wait = 1'b1; rand_lat = 1'b1; rand_ready = 1'b1;
            end else begin
                b = AW'($urandom); n = (AW + 1)'($urandom_range(0, 24));
                rand_wait = 1'($urandom); rand_lat = 1'($urandom); rand_ready = 1'($urandom);
            end
            start_fetch(b, n);
            wait_done(2000, to);
            cycles(3);
            checks++; if (to) begin failures++; $display("FAIL case%0d_timeout: no done within 2000 cycles", k); end
            checks++; if (issued_q.size() != int'(n)) begin failures++; $display("FAIL case%0d_reads: got %0d expected %0d", k, issued_q.size(), n); end
            sum = '0;
            for (int i = 0; i < int'(n); i++) begin
                ea  = b + AW'(i);
                ed  = mem[ea];
                sum = sum + ed;
                ga  = (i < issued_q.size()) ? issued_q[i] : ~ea;
                gd  = (i < recv_q.size()) ? recv_q[i] : ~ed;
                checks++; if (ga !== ea) begin failures++; $display("FAIL case%0d_addr[%0d]: got %h expected %h", k, i, ga, ea); end
                checks++; if (gd !== ed) begin failures++; $display("FAIL case%0d_data[%0d]: got %h expected %h", k, i, gd, ed); end
            end
            checks++; if (recv_q.size() != int'(n)) begin failures++; $display("FAIL case%0d_words: got %0d expected %0d", k, recv_q.size(), n); end
            checks++; if (done_cnt != 1) begin failures++; $display("FAIL case%0d_done_pulses: got %0d expected 1", k, done_cnt); end
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL case%0d_busy_after: got %b expected 0", k, busy); end
            checks++; if (max_occ > DEPTH) begin failures++; $display("FAIL case%0d_occupancy: got %0d expected <= %0d", k, max_occ, DEPTH); end
`ifdef CPU_MEM_FETCH_CHECKSUM_EN
            checks++; if (checksum !== sum) begin failures++; $display("FAIL case%0d_checksum: got %h expected %h", k, checksum, sum); end
`endif
        end
    endtask

    task automatic test_zero_count();
        rand_wait = 1'b0; rand_lat = 1'b0; rand_ready = 1'b0; ready_en = 1'b1;
        start_fetch(AW'($urandom), 15'd0);
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL zero_done_pulse: got %b expected 1", done); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL zero_busy_high: got %b expected 1", busy); end
        cycles(1);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL zero_done_low: got %b expected 0", done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL zero_busy_low: got %b expected 0", busy); end
        cycles(3);
        checks++; if (issued_q.size() != 0) begin failures++; $display("FAIL zero_reads: got %0d expected 0", issued_q.size()); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL zero_done_pulses: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_backpressure();
        logic [AW-1:0] b;
        logic [AW-1:0] ea;
        logic [AW-1:0] ga;
        logic [DW-1:0] ed;
        logic [DW-1:0] gd;
        bit            to;
        rand_wait = 1'b0; rand_lat = 1'b0; rand_ready = 1'b0; ready_en = 1'b0;
        b = AW'($urandom);
        start_fetch(b, 15'd8);
        cycles(10);
        // a second start while busy must be ignored
        start = 1'b1; base_addr = ~b; word_count = 15'd2;
        cycles(1);
        start = 1'b0;
        cycles(30);
        checks++; if (issued_q.size() > DEPTH) begin failures++; $display("FAIL bp_reads_held: got %0d expected <= %0d", issued_q.size(), DEPTH); end
        checks++; if (avm_read !== 1'b0) begin failures++; $display("FAIL bp_read_dropped: got %b expected 0", avm_read); end
        checks++; if (st_valid !== 1'b1) begin failures++; $display("FAIL bp_st_valid: got %b expected 1", st_valid); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL bp_busy: got %b expected 1", busy); end
        ready_en = 1'b1;
        wait_done(300, to);
        cycles(3);
        checks++; if (to) begin failures++; $display("FAIL bp_timeout: no done within 300 cycles"); end
        checks++; if (issued_q.size() != 8) begin failures++; $display("FAIL bp_reads: got %0d expected 8", issued_q.size()); end
        checks++; if (recv_q.size() != 8) begin failures++; $display("FAIL bp_words: got %0d expected 8", recv_q.size()); end
        for (int i = 0; i < 8; i++) begin
            ea = b + AW'(i);
            ed = mem[ea];
            ga = (i < issued_q.size()) ? issued_q[i] : ~ea;
            gd = (i < recv_q.size()) ? recv_q[i] : ~ed;
            checks++; if (ga !== ea) begin failures++; $display("FAIL bp_addr[%0d]: got %h expected %h", i, ga, ea); end
            checks++; if (gd !== ed) begin failures++; $display("FAIL bp_data[%0d]: got %h expected %h", i, gd, ed); end
        end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL bp_done_pulses: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_reset_mid_fetch();
        logic [AW-1:0] b;
        logic [AW-1:0] ea;
        logic [AW-1:0] ga;
        logic [DW-1:0] ed;
        logic [DW-1:0] gd;
        bit            to;
        rand_wait = 1'b1; rand_lat = 1'b1; rand_ready = 1'b1; ready_en = 1'b1;
        start_fetch(AW'($urandom), 15'd20);
        cycles(12);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rst_mid_busy_before: got %b expected 1", busy); end
        reset_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_mid_done: got %b expected 0", done); end
        checks++; if (avm_read !== 1'b0) begin failures++; $display("FAIL rst_mid_read: got %b expected 0", avm_read); end
        checks++; if (avm_address !== 14'h0000) begin failures++; $display("FAIL rst_mid_addr: got %h expected 0000", avm_address); end
        checks++; if (st_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_st_valid: got %b expected 0", st_valid); end
        cycles(2);
        reset_n  = 1'b1;
        rand_lat = 1'b0;
        // stale responses from the aborted fetch arrive now and must be dropped
        cycles(15);
        checks++; if (st_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_stale_data: got %b expected 0", st_valid); end
        checks++; if (done_cnt != 0) begin failures++; $display("FAIL rst_mid_no_done: got %0d expected 0", done_cnt); end
        rand_lat = 1'b1;
        b = AW'($urandom);
        start_fetch(b, 15'd10);
        wait_done(1000, to);
        cycles(3);
        checks++; if (to) begin failures++; $display("FAIL rst_mid_restart_timeout: no done within 1000 cycles"); end
        checks++; if (recv_q.size() != 10) begin failures++; $display("FAIL rst_mid_words: got %0d expected 10", recv_q.size()); end
        for (int i = 0; i < 10; i++) begin
            ea = b + AW'(i);
            ed = mem[ea];
            ga = (i < issued_q.size()) ? issued_q[i] : ~ea;
            gd = (i < recv_q.size()) ? recv_q[i] : ~ed;
            checks++; if (ga !== ea) begin failures++; $display("FAIL rst_mid_addr[%0d]: got %h expected %h", i, ga, ea); end
            checks++; if (gd !== ed) begin failures++; $display("FAIL rst_mid_data[%0d]: got %h expected %h", i, gd, ed); end
        end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL rst_mid_done_pulses: got %0d expected 1", done_cnt); end
    endtask

`ifdef CPU_MEM_FETCH_CHECKSUM_EN
    task automatic test_checksum();
        bit to;
        rand_wait = 1'b0; rand_lat = 1'b0; rand_ready = 1'b1; ready_en = 1'b1;
        mem[14'h0100] = 32'hFFFF_FFFF;
        mem[14'h0101] = 32'h0000_0002;
        start_fetch(14'h0100, 15'd2);
        wait_done(200, to);
        cycles(3);
        checks++; if (to) begin failures++; $display("FAIL cks_timeout: no done within 200 cycles"); end
        checks++; if (checksum !== 32'h0000_0001) begin failures++; $display("FAIL cks_wrap: got %h expected 00000001", checksum); end
    endtask
`endif

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
        test_reset();
        test_fetch_cases();
        test_zero_count();
        test_backpressure();
        test_reset_mid_fetch();
`ifdef CPU_MEM_FETCH_CHECKSUM_EN
        test_checksum();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_mem_fetch_master.md
CPU_MEM_FETCH_MASTER -- requirements
Module: cpu_mem_fetch_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 14: word-address width of the memory port.
REQ-002 SHALL have parameter DATA_W, default 32: data word width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4 (power of 2, at least 2): output buffer entries.
REQ-004 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  in  1  one-cycle request to begin a fetch.
REQ-007 SHALL have port base_addr  in  ADDR_W  first word address of the fetch.
REQ-008 SHALL have port word_count  in  ADDR_W+1  number of words to fetch; 0 is legal.
REQ-009 SHALL have port busy  out  1  high in every state except IDLE.
REQ-010 SHALL have port done  out  1  one-cycle pulse when a fetch completes.
REQ-011 SHALL have port avm_address  out  ADDR_W  Avalon-MM master word address.
REQ-012 SHALL have port avm_read  out  1  Avalon-MM read request.
REQ-013 SHALL have port avm_byteenable  out  4  driven constant 4'hF.
REQ-014 SHALL have port avm_waitrequest  in  1  slave stall.
REQ-015 SHALL have port avm_readdata  in  DATA_W  read data.
REQ-016 SHALL have port avm_readdatavalid  in  1  avm_readdata is valid this cycle.
REQ-017 SHALL have port st_data  out  DATA_W  stream output data (FIFO head).
REQ-018 SHALL have port st_valid  out  1  st_data is valid.
REQ-019 SHALL have port st_ready  in  1  sink accepts data.

Function
REQ-020 SHALL implement FSM states IDLE, ISSUE, DRAIN, DONE.
REQ-021 SHALL, in IDLE on start=1, latch base_addr and word_count and move to ISSUE next cycle, or to DONE if word_count=0.
REQ-022 SHALL ignore start in any state other than IDLE.
REQ-023 SHALL, in ISSUE, assert avm_read only when (fifo_used + outstanding) < FIFO_DEPTH.
REQ-024 SHALL treat a read as issued when avm_read=1 and avm_waitrequest=0; avm_address SHALL stay stable while avm_waitrequest=1.
REQ-025 SHALL increment the address after each issued read, wrapping from 2^ADDR_W-1 to 0.
REQ-026 SHALL move ISSUE to DRAIN on the cycle the last read is issued.
REQ-027 SHALL move DRAIN to DONE when outstanding=0 and the FIFO is empty.
REQ-028 SHALL assert done=1 for exactly one cycle in DONE, then return to IDLE.
REQ-029 SHALL push avm_readdata into the FIFO on every avm_readdatavalid=1, in issue order.
REQ-030 SHALL pop the FIFO on st_valid & st_ready; st_valid = FIFO not empty.
REQ-031 SHALL handle a simultaneous push and pop with fifo_used unchanged; a pop and a read-issue in the same cycle SHALL each update its own counter.
REQ-032 SHALL never overflow the FIFO; avm_readdatavalid arriving with no read outstanding SHALL be ignored.

Reset
REQ-033 SHALL asynchronously force the following on reset_n=0: FSM=IDLE, busy=0, done=0, avm_read=0, avm_address=0, st_valid=0, FIFO empty, outstanding=0.
REQ-034 SHALL discard any buffered and in-flight data when reset is asserted mid-fetch, with no done pulse.

Configuration
REQ-035 SHALL, with CPU_MEM_FETCH_CHECKSUM_EN defined, add output checksum [DATA_W] = modulo-2^DATA_W sum of all words popped in the current fetch, cleared on an accepted start and held after done.
REQ-036 SHALL, with CPU_MEM_FETCH_CHECKSUM_EN undefined, have no checksum port and no checksum logic.

Structure
REQ-037 SHALL place the FSM state enum and the default ADDR_W/DATA_W constants in package cpu_mem_fetch_pkg.
REQ-038 SHALL implement the buffer as sub-module cpu_mem_fetch_fifo (synchronous FIFO with count output).

Verification
REQ-039 SHALL cover: base=0x0010, count=3, no waitrequest, st_ready=1 -> reads to 0x0010..0x0012; st_data equals memory contents in order; one done pulse.
REQ-040 SHALL cover: count=0 -> no avm_read; done one cycle after start; busy high for exactly that cycle.
REQ-041 SHALL cover: base=0x3FFE, count=4 -> addresses 0x3FFE, 0x3FFF, 0x0000, 0x0001.
REQ-042 SHALL cover: st_ready=0, count=8 -> at most 4 reads issued, avm_read then drops; releasing st_ready completes all 8 words in order.
REQ-043 SHALL cover: random waitrequest plus reset_n pulse mid-fetch -> all outputs at reset values; a new start then completes normally.
REQ-044 SHALL cover, with CPU_MEM_FETCH_CHECKSUM_EN defined: words 0xFFFFFFFF, 0x00000002 -> checksum=0x00000001.
